act_skew_feeder: RTL and testbench

Activation feeder placed directly upstream of `systolic_array`. It accepts one row-aligned activation vector per cycle through a valid/ready handshake and delays lane k by k extra cycles, producing the diagonal wavefront the array consumes on `act_data_in`. It counts a tile of `tile_len` vectors, then drains zeros until the last lane has been presented, and signals completion with a one-cycle `done` pulse.

---
 rtl/act_skew_feeder_if.sv | 27 ++
 rtl/act_skew_feeder.sv | 124 ++++++++++++
 tb/tb_act_skew_feeder.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/act_skew_feeder_if.sv
// Handshake and skewed-output bundle between an activation source, the feeder
// and the systolic array it drives.
interface act_skew_feeder_if #(
  parameter int ACT_WIDTH      = 8,
  parameter int ARRAY_SIZE     = 2,
  parameter int TILE_LEN_WIDTH = 8
);
  logic                             start;
  logic [TILE_LEN_WIDTH-1:0]        tile_len;
  logic                             in_valid;
  logic                             in_ready;
  logic [ACT_WIDTH*ARRAY_SIZE-1:0]  in_data;
  logic [ACT_WIDTH*ARRAY_SIZE-1:0]  act_data_out;
  logic [ARRAY_SIZE-1:0]            act_valid_out;
  logic                             busy;
  logic                             done;

  modport master (
    output start, tile_len, in_valid, in_data,
    input  in_ready, act_data_out, act_valid_out, busy, done
  );

  modport slave (
    input  start, tile_len, in_valid, in_data,
    output in_ready, act_data_out, act_valid_out, busy, done
  );
endinterface

// File: rtl/act_skew_feeder.sv
// Skews row-aligned activation vectors into the diagonal wavefront a systolic
// array consumes: lane k is delayed k cycles, with tile framing and a done pulse.
module act_skew_feeder #(
  parameter int ACT_WIDTH      = 8,
  parameter int ARRAY_SIZE     = 2,
  parameter int TILE_LEN_WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  act_skew_feeder_if.slave  bus
);

  localparam int DRAIN_W = $clog2(ARRAY_SIZE + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t                          state_r;
  logic [TILE_LEN_WIDTH-1:0]       remaining_r;
  logic [DRAIN_W-1:0]              drain_cnt_r;
  logic                            in_ready_r;
  logic                            busy_r;
  logic                            done_r;
  logic                            accept_s;
  logic [ACT_WIDTH*ARRAY_SIZE-1:0] act_data_s;
  logic [ARRAY_SIZE-1:0]           act_valid_s;

  assign accept_s          = bus.in_valid & in_ready_r;
  assign bus.in_ready      = in_ready_r;
  assign bus.busy          = busy_r;
  assign bus.done          = done_r;
  assign bus.act_data_out  = act_data_s;
  assign bus.act_valid_out = act_valid_s;

  // Tile sequencing: count accepted vectors, then let the deepest lane empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      remaining_r <= {TILE_LEN_WIDTH{1'b0}};
      drain_cnt_r <= {DRAIN_W{1'b0}};
      in_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start && (bus.tile_len != {TILE_LEN_WIDTH{1'b0}})) begin
            state_r     <= STREAM;
            remaining_r <= bus.tile_len;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        STREAM: begin
          if (accept_s) begin
            remaining_r <= remaining_r - TILE_LEN_WIDTH'(1);
            if (remaining_r == TILE_LEN_WIDTH'(1)) begin
              state_r     <= DRAIN;
              drain_cnt_r <= DRAIN_W'(ARRAY_SIZE);
              in_ready_r  <= 1'b0;
            end else begin
              state_r <= STREAM;
            end
          end else begin
            state_r <= STREAM;
          end
        end
        DRAIN: begin
          drain_cnt_r <= drain_cnt_r - DRAIN_W'(1);
          if (drain_cnt_r == DRAIN_W'(1)) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            state_r <= DRAIN;
          end
        end
        default: begin
          state_r     <= IDLE;
          remaining_r <= {TILE_LEN_WIDTH{1'b0}};
          drain_cnt_r <= {DRAIN_W{1'b0}};
          in_ready_r  <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  for (genvar k = 0; k < ARRAY_SIZE; k++) begin : g_lane
    logic [ACT_WIDTH-1:0] data_r  [0:k];
    logic                 valid_r [0:k];
    logic [ACT_WIDTH-1:0] head_s;

    // Non-accepted cycles inject zero data so invalid lanes read as zero.
    assign head_s = accept_s ? bus.in_data[k*ACT_WIDTH +: ACT_WIDTH] : {ACT_WIDTH{1'b0}};

    // Lane k delay line of depth k+1; shifts every cycle regardless of state.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int j = 0; j <= k; j++) begin
          data_r[j]  <= {ACT_WIDTH{1'b0}};
          valid_r[j] <= 1'b0;
        end
      end else begin
        data_r[0]  <= head_s;
        valid_r[0] <= accept_s;
        for (int j = 1; j <= k; j++) begin
          data_r[j]  <= data_r[j-1];
          valid_r[j] <= valid_r[j-1];
        end
      end
    end

    assign act_data_s[k*ACT_WIDTH +: ACT_WIDTH] = data_r[k];
    assign act_valid_s[k]                       = valid_r[k];
  end

endmodule

// File: tb/tb_act_skew_feeder.sv
// Bench for act_skew_feeder: a 2-lane and a 4-lane instance checked every cycle
// against an accept-log model, plus hand-computed expectations from the test plan.
module tb_act_skew_feeder;

  localparam int KEY = 1000000;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  start_v;
  logic [1:0]  in_valid_v;
  logic [7:0]  len_v     [2];
  logic [31:0] in_data_v [2];
  logic [31:0] out_data  [2];
  logic [3:0]  out_valid [2];
  logic [1:0]  out_busy, out_done, out_ready;

  int n_checks = 0;
  int n_pass   = 0;

  // model state
  int          edge_n = 0;
  int          flo      [2];
  int          m_cnt    [2];
  int          m_len    [2];
  int          m_last   [2];
  bit          m_active [2];
  bit          m_done   [2];
  logic [31:0] acc_log  [int];

  bit          cnt_en = 1'b0;
  int          vcnt [4];

  act_skew_feeder_if #(.ACT_WIDTH(8), .ARRAY_SIZE(2), .TILE_LEN_WIDTH(8)) b2 ();
  act_skew_feeder_if #(.ACT_WIDTH(8), .ARRAY_SIZE(4), .TILE_LEN_WIDTH(8)) b4 ();

  act_skew_feeder #(.ACT_WIDTH(8), .ARRAY_SIZE(2), .TILE_LEN_WIDTH(8)) u2 (
    .clk(clk), .reset(rst), .bus(b2));
  act_skew_feeder #(.ACT_WIDTH(8), .ARRAY_SIZE(4), .TILE_LEN_WIDTH(8)) u4 (
    .clk(clk), .reset(rst), .bus(b4));

  assign b2.start    = start_v[0];
  assign b2.tile_len = len_v[0];
  assign b2.in_valid = in_valid_v[0];
  assign b2.in_data  = in_data_v[0][15:0];
  assign b4.start    = start_v[1];
  assign b4.tile_len = len_v[1];
  assign b4.in_valid = in_valid_v[1];
  assign b4.in_data  = in_data_v[1];

  assign out_data[0]  = {16'h0000, b2.act_data_out};
  assign out_valid[0] = {2'b00, b2.act_valid_out};
  assign out_data[1]  = b4.act_data_out;
  assign out_valid[1] = b4.act_valid_out;
  assign out_busy     = {b4.busy, b2.busy};
  assign out_done     = {b4.done, b2.done};
  assign out_ready    = {b4.in_ready, b2.in_ready};

  always #5 clk = ~clk;

  task automatic check(string nm, int d, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d edge %0d: got %h want %h", nm, d, edge_n, act, exp);
  endtask

  task automatic model_clear(int d);
    m_active[d] = 1'b0;
    m_done[d]   = 1'b0;
    m_cnt[d]    = 0;
    m_len[d]    = 0;
    m_last[d]   = -1;
    flo[d]      = edge_n;
  endtask

  // Advance the model across one rising edge using the inputs held before it.
  task automatic model_edge();
    edge_n++;
    for (int d = 0; d < 2; d++) begin
      int n;
      n = (d == 0) ? 2 : 4;
      m_done[d] = 1'b0;
      if (rst) begin
        model_clear(d);
      end else if (m_active[d] && m_last[d] >= 0 && edge_n == m_last[d] + n) begin
        m_active[d] = 1'b0;
        m_done[d]   = 1'b1;
      end else if (m_active[d] && m_cnt[d] < m_len[d]) begin
        if (in_valid_v[d]) begin
          acc_log[d*KEY + edge_n] = in_data_v[d];
          m_cnt[d]++;
          if (m_cnt[d] == m_len[d]) m_last[d] = edge_n;
        end
      end else if (!m_active[d] && start_v[d] && len_v[d] != 8'd0) begin
        m_active[d] = 1'b1;
        m_len[d]    = int'(len_v[d]);
        m_cnt[d]    = 0;
        m_last[d]   = -1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #2;
  endtask

  // Per-cycle comparison of both instances against the model.
  initial forever begin
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      int          n;
      int          src;
      logic [31:0] ed;
      logic [31:0] ent;
      logic [3:0]  ev;
      n  = (d == 0) ? 2 : 4;
      ed = 32'h0;
      ev = 4'h0;
      for (int k = 0; k < n; k++) begin
        src = edge_n - k;
        if (src > flo[d] && acc_log.exists(d*KEY + src)) begin
          ent = acc_log[d*KEY + src];
          ev[k] = 1'b1;
          ed[k*8 +: 8] = ent[k*8 +: 8];
        end
      end
      check("act_data", d, out_data[d], ed);
      check("act_valid", d, {28'h0, out_valid[d]}, {28'h0, ev});
      check("busy", d, {31'h0, out_busy[d]}, {31'h0, m_active[d]});
      check("done", d, {31'h0, out_done[d]}, {31'h0, m_done[d]});
      check("in_ready", d, {31'h0, out_ready[d]},
            {31'h0, (m_active[d] && m_cnt[d] < m_len[d])});
    end
    if (cnt_en) begin
      for (int k = 0; k < 4; k++) vcnt[k] += int'(out_valid[1][k]);
    end
  end

  initial begin
    int          done_seen;
    int          last_acc;
    int          done_edge;
    logic [31:0] vec [5];

    for (int d = 0; d < 2; d++) model_clear(d);
    rst        = 1'b1;
    start_v    = 2'b01;
    in_valid_v = 2'b01;
    len_v[0]   = 8'd2;
    len_v[1]   = 8'd0;
    in_data_v[0] = 32'h0000_0301;
    in_data_v[1] = 32'h0;

    // reset held with start/in_valid high
    step(); step();
    check("rst_data", 0, out_data[0], 32'h0);
    check("rst_valid", 0, {28'h0, out_valid[0]}, 32'h0);
    check("rst_busy_ready_done", 0, {29'h0, out_busy[0], out_ready[0], out_done[0]}, 32'h0);
    rst = 1'b0;

    // back-to-back tile {03,01},{04,02}
    step();
    check("busy_after_start", 0, {31'h0, out_busy[0]}, 32'h1);
    check("ready_after_start", 0, {31'h0, out_ready[0]}, 32'h1);
    start_v = 2'b00;
    step();
    check("b2b_e0", 0, {out_data[0][15:0], 12'h0, out_valid[0]}, {16'h0001, 16'h0001});
    in_data_v[0] = 32'h0000_0402;
    step();
    check("b2b_e1", 0, {out_data[0][15:0], 12'h0, out_valid[0]}, {16'h0302, 16'h0003});
    in_valid_v = 2'b00;
    step();
    check("b2b_e2", 0, {out_data[0][15:0], 12'h0, out_valid[0]}, {16'h0400, 16'h0002});
    check("b2b_e2_done", 0, {31'h0, out_done[0]}, 32'h0);
    step();
    check("b2b_e3", 0, {out_data[0][15:0], 12'h0, out_valid[0]}, 32'h0);
    check("b2b_done", 0, {30'h0, out_done[0], out_busy[0]}, 32'h2);
    step();
    check("b2b_done_pulse", 0, {31'h0, out_done[0]}, 32'h0);

    // same tile with a bubble
    start_v = 2'b01; len_v[0] = 8'd2;
    step();
    start_v = 2'b00; in_valid_v = 2'b01; in_data_v[0] = 32'h0000_0301;
    step();
    in_valid_v = 2'b00;
    step();
    check("bub_e1", 0, {out_data[0][15:0], 12'h0, out_valid[0]}, {16'h0300, 16'h0002});
    in_valid_v = 2'b01; in_data_v[0] = 32'h0000_0402;
    step();
    check("bub_e2", 0, {out_data[0][15:0], 12'h0, out_valid[0]}, {16'h0002, 16'h0001});
    in_valid_v = 2'b00;
    step();
    check("bub_e3", 0, {out_data[0][15:0], 12'h0, out_valid[0]}, {16'h0400, 16'h0002});
    check("bub_e3_done", 0, {31'h0, out_done[0]}, 32'h0);
    step();
    check("bub_done", 0, {31'h0, out_done[0]}, 32'h1);
    step();

    // start ignored: zero length in IDLE, pulses in STREAM and DRAIN
    start_v = 2'b01; len_v[0] = 8'd0;
    step();
    check("zero_len_idle", 0, {30'h0, out_busy[0], out_ready[0]}, 32'h0);
    len_v[0] = 8'd3;
    step();
    len_v[0] = 8'd5; in_valid_v = 2'b01;
    for (int i = 0; i < 3; i++) begin
      in_data_v[0] = 32'h0000_1110 + i;
      step();
    end
    in_valid_v = 2'b00;
    done_seen = 0;
    step();
    done_seen += int'(out_done[0]);
    start_v = 2'b00;
    for (int i = 0; i < 4; i++) begin
      step();
      done_seen += int'(out_done[0]);
    end
    check("ign_done_count", 0, done_seen, 32'd1);
    check("ign_idle", 0, {30'h0, out_busy[0], out_ready[0]}, 32'h0);

    // asynchronous reset one cycle after the first accept of a 3-vector tile
    start_v = 2'b01; len_v[0] = 8'd3;
    step();
    start_v = 2'b00; in_valid_v = 2'b01; in_data_v[0] = 32'h0000_0a0b;
    step();
    in_data_v[0] = 32'h0000_0c0d;
    step();
    #1;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) model_clear(d);
    #1;
    check("arst_data", 0, out_data[0], 32'h0);
    check("arst_valid_busy_ready", 0, {27'h0, out_valid[0], out_busy[0]}, 32'h0);
    check("arst_ready", 0, {31'h0, out_ready[0]}, 32'h0);
    in_valid_v = 2'b00;
    step();
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      done_seen += int'(out_done[0]);
    end
    check("arst_no_done", 0, done_seen, 32'd0);

    start_v = 2'b01; len_v[0] = 8'd1;
    step();
    start_v = 2'b00; in_valid_v = 2'b01; in_data_v[0] = 32'h0000_0506;
    step();
    in_valid_v = 2'b00;
    check("one_lane0", 0, {out_data[0][15:0], 12'h0, out_valid[0]}, {16'h0006, 16'h0001});
    step();
    check("one_lane1", 0, {out_data[0][15:0], 12'h0, out_valid[0]}, {16'h0500, 16'h0002});
    step();
    check("one_done", 0, {31'h0, out_done[0]}, 32'h1);
    step();

    // 4-lane instance, 5 random vectors back-to-back
    start_v = 2'b10; len_v[1] = 8'd5;
    step();
    start_v = 2'b00;
    for (int k = 0; k < 4; k++) vcnt[k] = 0;
    cnt_en = 1'b1;
    in_valid_v = 2'b10;
    for (int i = 0; i < 5; i++) begin
      vec[i] = $urandom;
      in_data_v[1] = vec[i];
      step();
    end
    last_acc = edge_n;
    in_valid_v = 2'b00;
    step(); step(); step();
    check("w4_lane3_last", 1, {out_data[1][31:24], 20'h0, out_valid[1]},
          {vec[4][31:24], 24'h000008});
    done_edge = -1;
    for (int i = 0; i < 12 && done_edge < 0; i++) begin
      step();
      if (out_done[1]) done_edge = edge_n;
    end
    check("w4_done_edge", 1, done_edge, last_acc + 4);
    step(); step();
    cnt_en = 1'b0;
    for (int k = 0; k < 4; k++) check($sformatf("w4_lane%0d_count", k), 1, vcnt[k], 32'd5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
